// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants and FSM state type for the RMII receive dibit packer
package eth_pkg;

  localparam int DECIM10_DEFAULT = 10;
  localparam int DIBITS_PER_BYTE = 4;

  localparam logic SPEED_100 = 1'b0;
  localparam logic SPEED_10  = 1'b1;

  typedef enum logic {
    PK_IDLE   = 1'b0,
    PK_ACTIVE = 1'b1
  } pk_state_t;

endpackage

// File: rtl/eth_rx_dibit_strobe.sv
// rtl/eth_rx_dibit_strobe.sv - per-dibit sample strobe: every clock at 100M, mid-dibit at 10M
module eth_rx_dibit_strobe
  import eth_pkg::*;
#(
  parameter int pDecim10 = DECIM10_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Speed_10,
  input  logic Restart,
  output logic Strobe
);

  localparam int CW = (pDecim10 > 1) ? $clog2(pDecim10) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_cur;

  // Restart makes the current cycle count 0, so the first dibit is sampled mid-way.
  assign cnt_cur = Restart ? '0 : cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (cnt_cur == CW'(pDecim10 - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_cur + CW'(1);
    end
  end

  assign Strobe = (Speed_10 == SPEED_10) ? (cnt_cur == CW'(pDecim10 / 2)) : 1'b1;

endmodule

// File: rtl/eth_rx_dibit_pack.sv
// rtl/eth_rx_dibit_pack.sv - RMII dibit-to-byte packer with frame byte count and alignment flag
// Optional: ETH_RX_CRS_TOGGLE_EN bridges end-of-frame CRS_DV toggling (two low samples end a frame).
module eth_rx_dibit_pack
  import eth_pkg::*;
#(
  parameter int pDecim10 = DECIM10_DEFAULT,
  parameter int pCnt_W   = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Crs_Dv,
  input  logic [1:0]        Rxd,
  input  logic              Rx_En,
  input  logic              Speed_10,
  output logic [7:0]        Byte,
  output logic              Byte_Rdy,
  output logic [pCnt_W-1:0] Frame_Bytes,
  output logic              Align_Err
);

  localparam logic [1:0] LAST_DIBIT = 2'(DIBITS_PER_BYTE - 1);

  pk_state_t  state, state_nxt;
  logic       rx_en_d;
  logic       rise;
  logic       strobe;
  logic       dv_eff;
  logic       accept;
  logic       frame_end;
  logic [1:0] dibit_cnt;
  logic [1:0] dibit_cur;
  logic [5:0] sr;

  assign rise      = Rx_En & ~rx_en_d;
  assign dibit_cur = rise ? 2'd0 : dibit_cnt;

  eth_rx_dibit_strobe #(
    .pDecim10 (pDecim10)
  ) u_strobe (
    .Clk      (Clk),
    .Rst      (Rst),
    .Speed_10 (Speed_10),
    .Restart  (rise),
    .Strobe   (strobe)
  );

`ifdef ETH_RX_CRS_TOGGLE_EN
  logic dv_prev;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      dv_prev <= 1'b0;
    end else if (strobe) begin
      dv_prev <= Crs_Dv;
    end
  end

  assign dv_eff = Crs_Dv | dv_prev;
`else
  assign dv_eff = Crs_Dv;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= PK_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    frame_end = 1'b0;
    case (state)
      PK_IDLE: begin
        if (rise) begin
          state_nxt = PK_ACTIVE;
          accept    = dv_eff & strobe;
        end
      end
      PK_ACTIVE: begin
        if (!Rx_En || (strobe && !dv_eff)) begin
          state_nxt = PK_IDLE;
          frame_end = 1'b1;
        end else begin
          accept = dv_eff & strobe;
        end
      end
      default: state_nxt = PK_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_en_d     <= 1'b0;
      Byte        <= '0;
      Byte_Rdy    <= 1'b0;
      Align_Err   <= 1'b0;
      Frame_Bytes <= '0;
      dibit_cnt   <= '0;
      sr          <= '0;
    end else begin
      rx_en_d   <= Rx_En;
      Byte_Rdy  <= 1'b0;
      Align_Err <= 1'b0;
      if (rise) begin
        Frame_Bytes <= '0;
        dibit_cnt   <= '0;
      end
      if (accept) begin
        if (dibit_cur == LAST_DIBIT) begin
          Byte      <= {Rxd, sr};
          Byte_Rdy  <= 1'b1;
          dibit_cnt <= '0;
          if (Frame_Bytes != '1) begin
            Frame_Bytes <= Frame_Bytes + pCnt_W'(1);
          end
        end else begin
          case (dibit_cur)
            2'd0:    sr[1:0] <= Rxd;
            2'd1:    sr[3:2] <= Rxd;
            default: sr[5:4] <= Rxd;
          endcase
          dibit_cnt <= dibit_cur + 2'd1;
        end
      end
      // Partial byte at frame end is dropped and flagged.
      if (frame_end) begin
        Align_Err <= (dibit_cnt != 2'd0);
        dibit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_dibit_pack.sv
// tb/tb_eth_rx_dibit_pack.sv - directed self-checking bench for eth_rx_dibit_pack
`timescale 1ns/1ps
module tb_eth_rx_dibit_pack;

  localparam int pDecim10 = 10;
  localparam int pCnt_W   = 16;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              Crs_Dv = 1'b0;
  logic [1:0]        Rxd = 2'b00;
  logic              Rx_En = 1'b0;
  logic              Speed_10 = 1'b0;
  logic [7:0]        Byte;
  logic              Byte_Rdy;
  logic [pCnt_W-1:0] Frame_Bytes;
  logic              Align_Err;

  int         n_chk = 0;
  int         n_err = 0;
  int         rdy_cnt = 0;
  int         ae_cnt = 0;
  logic [7:0] rx_q[$];
  time        rdy_t[$];
  time        t0;
  int         mism;

  always #10 Clk = ~Clk;

  eth_rx_dibit_pack #(
    .pDecim10 (pDecim10),
    .pCnt_W   (pCnt_W)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Crs_Dv      (Crs_Dv),
    .Rxd         (Rxd),
    .Rx_En       (Rx_En),
    .Speed_10    (Speed_10),
    .Byte        (Byte),
    .Byte_Rdy    (Byte_Rdy),
    .Frame_Bytes (Frame_Bytes),
    .Align_Err   (Align_Err)
  );

  // Pulse monitor samples on the falling edge; stimulus acts 1 ns later.
  always @(negedge Clk) begin
    if (Byte_Rdy) begin
      rdy_cnt++;
      rx_q.push_back(Byte);
      rdy_t.push_back($time);
    end
    if (Align_Err) ae_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic put(input logic [1:0] d, input logic dv, input int hold);
    Rxd    = d;
    Crs_Dv = dv;
    idle(hold);
  endtask

  task automatic put_byte(input logic [7:0] b, input int hold);
    for (int k = 0; k < 4; k++) put(b[2*k +: 2], 1'b1, hold);
  endtask

  task automatic clear_mon();
    rdy_cnt = 0;
    ae_cnt  = 0;
    rx_q.delete();
    rdy_t.delete();
  endtask

  initial begin
    idle(3);
    check("rst_byte", 32'(Byte), 32'h0);
    check("rst_rdy", 32'(Byte_Rdy), 32'h0);
    check("rst_fbytes", 32'(Frame_Bytes), 32'h0);
    check("rst_aerr", 32'(Align_Err), 32'h0);
    Rst = 1'b0;
    idle(2);
    clear_mon();

    // 100M single byte, Rx_En drops right after the 4th dibit
    Rx_En = 1'b1;
    put(2'b01, 1'b1, 1);
    put(2'b00, 1'b1, 1);
    put(2'b11, 1'b1, 1);
    put(2'b10, 1'b1, 1);
    check("b1_rdy", 32'(Byte_Rdy), 32'h1);
    check("b1_byte", 32'(Byte), 32'hB1);
    check("b1_fbytes", 32'(Frame_Bytes), 32'd1);
    Rx_En  = 1'b0;
    Crs_Dv = 1'b0;
    idle(1);
    check("b1_rdy_off", 32'(Byte_Rdy), 32'h0);
    check("b1_aerr", 32'(Align_Err), 32'h0);
    idle(3);
    check("b1_npulse", 32'(rdy_cnt), 32'd1);
    check("b1_nae", 32'(ae_cnt), 32'd0);

    // 100M 64-byte frame, Crs_Dv drops after the last dibit
    clear_mon();
    Rx_En = 1'b1;
    for (int b = 0; b < 64; b++) put_byte(8'(b), 1);
    put(2'b00, 1'b0, 1);
    idle(2);
    Rx_En = 1'b0;
    idle(2);
    mism = 0;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(i)) mism++;
    check("f64_npulse", 32'(rdy_cnt), 32'd64);
    check("f64_seq", 32'(mism), 32'd0);
    check("f64_byte", 32'(Byte), 32'h3F);
    check("f64_fbytes", 32'(Frame_Bytes), 32'd64);
`ifdef ETH_RX_CRS_TOGGLE_EN
    check("f64_nae", 32'(ae_cnt), 32'd1);
`else
    check("f64_nae", 32'(ae_cnt), 32'd0);
`endif

    // 10M: two bytes, each dibit held 10 clocks
    Speed_10 = 1'b1;
    clear_mon();
    t0    = $time;
    Rx_En = 1'b1;
    put_byte(8'hA5, 10);
    put_byte(8'h3C, 10);
    Rx_En  = 1'b0;
    Crs_Dv = 1'b0;
    idle(3);
    check("s10_npulse", 32'(rdy_cnt), 32'd2);
    check("s10_byte0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'hA5);
    check("s10_byte1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'h3C);
    check("s10_lat", 32'(rdy_t.size() > 0 ? rdy_t[0] - t0 : 0), 32'd719);
    check("s10_gap", 32'(rdy_t.size() > 1 ? rdy_t[1] - rdy_t[0] : 0), 32'd800);
    check("s10_nae", 32'(ae_cnt), 32'd0);
    Speed_10 = 1'b0;
    idle(2);

    // Frame ends two dibits into a byte
    clear_mon();
    Rx_En = 1'b1;
    put_byte(8'h96, 1);
    put(2'b11, 1'b1, 1);
    put(2'b01, 1'b1, 1);
    put(2'b00, 1'b0, 1);
    idle(2);
    Rx_En = 1'b0;
    idle(2);
    check("ae_npulse", 32'(rdy_cnt), 32'd1);
    check("ae_byte", 32'(Byte), 32'h96);
    check("ae_fbytes", 32'(Frame_Bytes), 32'd1);
    check("ae_nae", 32'(ae_cnt), 32'd1);

    // Crs_Dv toggling over the last byte 8'h5A
    clear_mon();
    Rx_En = 1'b1;
    put_byte(8'h11, 1);
    put(2'b10, 1'b1, 1);
    put(2'b10, 1'b0, 1);
    put(2'b01, 1'b1, 1);
    put(2'b01, 1'b1, 1);
    put(2'b00, 1'b0, 1);
    put(2'b00, 1'b0, 1);
    idle(2);
    Rx_En = 1'b0;
    idle(2);
`ifdef ETH_RX_CRS_TOGGLE_EN
    check("tg_npulse", 32'(rdy_cnt), 32'd2);
    check("tg_byte", 32'(Byte), 32'h5A);
    check("tg_fbytes", 32'(Frame_Bytes), 32'd2);
`else
    check("tg_npulse", 32'(rdy_cnt), 32'd1);
    check("tg_byte", 32'(Byte), 32'h11);
    check("tg_fbytes", 32'(Frame_Bytes), 32'd1);
`endif
    check("tg_nae", 32'(ae_cnt), 32'd1);

    // Reset mid-byte, then a fresh frame packs from dibit 0
    clear_mon();
    Rx_En = 1'b1;
    put(2'b11, 1'b1, 1);
    put(2'b11, 1'b1, 1);
    Rst = 1'b1;
    idle(1);
    check("mr_byte", 32'(Byte), 32'h0);
    check("mr_rdy", 32'(Byte_Rdy), 32'h0);
    check("mr_fbytes", 32'(Frame_Bytes), 32'h0);
    check("mr_aerr", 32'(Align_Err), 32'h0);
    Rst   = 1'b0;
    Rx_En = 1'b0;
    idle(1);
    Rx_En = 1'b1;
    put_byte(8'hC3, 1);
    Rx_En  = 1'b0;
    Crs_Dv = 1'b0;
    idle(3);
    check("mr_npulse", 32'(rdy_cnt), 32'd1);
    check("mr_newbyte", 32'(Byte), 32'hC3);
    check("mr_nae", 32'(ae_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
